// File: rtl/gcd_bcd_core.sv
// rtl/gcd_bcd_core.sv - subtractive GCD engine with double-dabble BCD formatting of operands and result
module gcd_bcd_core #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] gcd_o,
    output logic [7:0]       data_a_o [DIGITS-1:0],
    output logic [7:0]       data_b_o [DIGITS-1:0],
    output logic [7:0]       data_o   [DIGITS-1:0]
);

    localparam int SW = 4 * DIGITS + WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GCD,
        S_CONV,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] x, y, op_a, op_b, res;
    logic [SW-1:0]    sc_a, sc_b, sc_r;
    logic [3:0]       cnt;
    logic             gcd_term;
    logic [WIDTH-1:0] gcd_val;
    logic             conv_last;

    // x==0 yields y; y==0 and x==y both yield x
    assign gcd_term  = (x == '0) || (y == '0) || (x == y);
    assign gcd_val   = (x == '0) ? y : x;
    assign conv_last = (cnt == 4'(WIDTH));

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    function automatic logic [SW-1:0] dabble(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic [3:0]    nib;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            nib = v[WIDTH + 4*d +: 4];
            if (nib >= 4'd5)
                r[WIDTH + 4*d +: 4] = nib + 4'd3;
        end
        return r << 1;
    endfunction

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_GCD;
            S_GCD:  if (gcd_term) state_nx = S_CONV;
            S_CONV: if (conv_last) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            x     <= '0;
            y     <= '0;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            sc_a  <= '0;
            sc_b  <= '0;
            sc_r  <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            gcd_o <= '0;
            for (int d = 0; d < DIGITS; d++) begin
                data_a_o[d] <= '0;
                data_b_o[d] <= '0;
                data_o[d]   <= '0;
            end
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x    <= a_i;
                        y    <= b_i;
                        op_a <= a_i;
                        op_b <= b_i;
                    end
                end
                S_GCD: begin
                    if (gcd_term) begin
                        res  <= gcd_val;
                        sc_a <= SW'(op_a);
                        sc_b <= SW'(op_b);
                        sc_r <= SW'(gcd_val);
                        cnt  <= '0;
                    end else if (x > y) begin
                        x <= x - y;
                    end else begin
                        y <= y - x;
                    end
                end
                S_CONV: begin
                    if (!conv_last) begin
                        sc_a <= dabble(sc_a);
                        sc_b <= dabble(sc_b);
                        sc_r <= dabble(sc_r);
                        cnt  <= cnt + 4'd1;
                    end else begin
                        // all display outputs update together on entry to DONE
                        gcd_o <= res;
                        err   <= (op_a == '0) && (op_b == '0);
                        for (int d = 0; d < DIGITS; d++) begin
                            data_a_o[d] <= {4'h0, sc_a[WIDTH + 4*d +: 4]};
                            data_b_o[d] <= {4'h0, sc_b[WIDTH + 4*d +: 4]};
                            data_o[d]   <= {4'h0, sc_r[WIDTH + 4*d +: 4]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_bcd_core.sv
// tb/tb_gcd_bcd_core.sv - table-driven bench for gcd_bcd_core
module tb_gcd_bcd_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a_i, b_i;
    logic       busy, done, err;
    logic [7:0] gcd_o;
    logic [7:0] data_a_o [2:0];
    logic [7:0] data_b_o [2:0];
    logic [7:0] data_o   [2:0];

    int n_total = 0;
    int n_pass  = 0;

    gcd_bcd_core #(.WIDTH(8), .DIGITS(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .gcd_o    (gcd_o),
        .data_a_o (data_a_o),
        .data_b_o (data_b_o),
        .data_o   (data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  g;
        int          lat;
        logic        e;
        logic [11:0] da;
        logic [11:0] db;
        logic [11:0] dg;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [23:0] exp24(input logic [11:0] e);
        return {4'h0, e[11:8], 4'h0, e[7:4], 4'h0, e[3:0]};
    endfunction

    function automatic logic [23:0] act24(input logic [7:0] d [2:0]);
        return {d[2], d[1], d[0]};
    endfunction

    function automatic logic all_zero();
        return !busy && !done && !err && gcd_o == 8'd0 &&
               act24(data_a_o) == 24'd0 && act24(data_b_o) == 24'd0 && act24(data_o) == 24'd0;
    endfunction

    // start is sampled at edge k; lat = number of edges after k until done is seen high
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        a_i = a; b_i = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int  lat;
        int  cyc;
        logic stable;
        logic saw_done;

        vecs[0] = '{8'd48,  8'd18,  8'd6,   14,  1'b0, 12'h048, 12'h018, 12'h006};
        vecs[1] = '{8'd255, 8'd255, 8'd255, 10,  1'b0, 12'h255, 12'h255, 12'h255};
        vecs[2] = '{8'd1,   8'd255, 8'd1,   264, 1'b0, 12'h001, 12'h255, 12'h001};
        vecs[3] = '{8'd0,   8'd45,  8'd45,  10,  1'b0, 12'h000, 12'h045, 12'h045};
        vecs[4] = '{8'd0,   8'd0,   8'd0,   10,  1'b1, 12'h000, 12'h000, 12'h000};
        vecs[5] = '{8'd100, 8'd75,  8'd25,  13,  1'b0, 12'h100, 12'h075, 12'h025};
        vecs[6] = '{8'd7,   8'd0,   8'd7,   10,  1'b0, 12'h007, 12'h000, 12'h007};

        rst_n = 1'b0; start = 1'b0; a_i = 8'd0; b_i = 8'd0;
        repeat (2) @(posedge clk);
        #1 chk("reset_outputs_zero", 32'(all_zero()), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1 if (!all_zero()) stable = 1'b0;
        end
        chk("idle_after_reset_stable", 32'(stable), 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_busy_in_done", i), 32'(busy), 32'd1);
            chk($sformatf("v%0d_gcd", i), 32'(gcd_o), 32'(vecs[i].g));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e));
            chk($sformatf("v%0d_digits_a", i), 32'(act24(data_a_o)), 32'(exp24(vecs[i].da)));
            chk($sformatf("v%0d_digits_b", i), 32'(act24(data_b_o)), 32'(exp24(vecs[i].db)));
            chk($sformatf("v%0d_digits_gcd", i), 32'(act24(data_o)), 32'(exp24(vecs[i].dg)));
            @(posedge clk);
            #1 chk($sformatf("v%0d_done_one_cycle", i), 32'({done, busy}), 32'd0);
            chk($sformatf("v%0d_gcd_held", i), 32'(gcd_o), 32'(vecs[i].g));
        end

        // second start during GCD is ignored; outputs hold the previous result meanwhile
        @(negedge clk);
        a_i = 8'd48; b_i = 8'd18; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            if (c == 3) chk("proto_gcd_held_while_busy", 32'(gcd_o), 32'd7);
            if (c == 4) begin a_i = 8'd9; b_i = 8'd3; start = 1'b1; end
            if (c == 5) start = 1'b0;
            if (done) begin lat = c; break; end
        end
        chk("proto_latency", 32'(lat), 32'd14);
        chk("proto_gcd", 32'(gcd_o), 32'd6);
        chk("proto_digits_a", 32'(act24(data_a_o)), 32'(exp24(12'h048)));

        // reset mid-computation aborts with no done and clears outputs
        @(negedge clk);
        a_i = 8'd9; b_i = 8'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        repeat (7) begin @(posedge clk); cyc++; end
        #3 rst_n = 1'b0;
        #1 chk("abort_outputs_zero", 32'(all_zero()), 32'd1);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (300) begin
            @(posedge clk);
            #1 if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        chk("abort_still_zero", 32'(all_zero()), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
